// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard receiver producing 11-bit key events
module ps2_key_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic [7:0]  raw_code,
    output logic        raw_stb,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchronisers, idle-high like the bus itself
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    // Clock filter
    logic          clk_f_q, clk_f_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall;

    // Frame receiver
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_ok;
    logic          err;

    // Sequence decoder and outputs
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [2:0]    skip_q, skip_d;
    logic [10:0]   key_q, key_d;
    logic [7:0]    raw_code_q, raw_code_d;
    logic          raw_stb_q, raw_stb_d;
    logic          frame_err_q, frame_err_d;

    // Two-flop synchronisers on both pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock follows the pin only after FILTER stable cycles at a new level
    always_comb begin
        clk_f_d   = clk_f_q;
        flt_cnt_d = flt_cnt_q;
        if (clk_s2_q == clk_f_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == FW'(FILTER - 1)) begin
            clk_f_d   = clk_s2_q;
            flt_cnt_d = '0;
        end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
        end
        // Edge is flagged in the cycle the filter commits to low, so data is sampled then
        fall = clk_f_q & ~clk_f_d;
    end

    // Filter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_f_q   <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            clk_f_q   <= clk_f_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; abort on inactivity
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        byte_ok = 1'b0;
        err     = 1'b0;
        tmo_d   = (fall || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!dat_s2_q) begin
                        state_d = ST_SHIFT;
                        cnt_d   = 4'd1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    if (cnt_q <= 4'd8) begin
                        shift_d = {dat_s2_q, shift_q[7:1]};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (cnt_q == 4'd9) begin
                        par_d = dat_s2_q;
                        cnt_d = 4'd10;
                    end else begin
                        // Parity is judged with the stop bit so a bad frame reports once
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                        if (dat_s2_q && (^{shift_q, par_q})) begin
                            byte_ok = 1'b1;
                        end else begin
                            err = 1'b1;
                        end
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    err     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Frame FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
        end
    end

    // Scan-code sequence decoder: prefixes, Pause skip, protocol replies, key events
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        skip_d      = skip_q;
        key_d       = {1'b0, key_q[9:0]};
        raw_code_d  = raw_code_q;
        raw_stb_d   = 1'b0;
        frame_err_d = err;
        if (err) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = 3'd0;
        end else if (byte_ok) begin
            raw_code_d = shift_q;
            raw_stb_d  = 1'b1;
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (shift_q)
                    8'hE0: ext_d  = 1'b1;
                    8'hF0: brk_d  = 1'b1;
                    8'hE1: skip_d = 3'd7;
                    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                        // Device replies carry no key information
                    end
                    default: begin
                        key_d = {1'b1, ~brk_q, ext_q, shift_q};
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Decoder and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            skip_q      <= 3'd0;
            key_q       <= 11'h000;
            raw_code_q  <= 8'h00;
            raw_stb_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            skip_q      <= skip_d;
            key_q       <= key_d;
            raw_code_q  <= raw_code_d;
            raw_stb_q   <= raw_stb_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ps2_key   = key_q;
    assign raw_code  = raw_code_q;
    assign raw_stb   = raw_stb_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - self-checking bench for ps2_key_rx
module tb_ps2_key_rx;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 20000;
    localparam int HALF    = 20;

    logic        clk;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic [7:0]  raw_code;
    logic        raw_stb;
    logic        frame_err;

    ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .raw_code  (raw_code),
        .raw_stb   (raw_stb),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Observed strobes since the last clear
    int         n_raw, n_key, n_err;
    logic [7:0] last_raw;
    logic [9:0] last_key;

    always @(negedge clk) begin
        if (raw_stb) begin
            n_raw    <= n_raw + 1;
            last_raw <= raw_code;
        end
        if (ps2_key[10]) begin
            n_key    <= n_key + 1;
            last_key <= ps2_key[9:0];
        end
        if (frame_err) n_err <= n_err + 1;
    end

    // Reference decoder state
    bit       m_ext, m_brk;
    int       m_skip;

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        int         e_raw;
        int         e_key;
        logic [9:0] e_kv;
        int         e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        @(posedge clk);
        #1;
        n_raw = 0;
        n_key = 0;
        n_err = 0;
    endtask

    // Drive the first nbits bits of a device-to-host frame
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Expected outcome of one frame from the sequence rules
    task automatic model(input logic [7:0] b, input bit good, output int e_raw, output int e_key,
                         output logic [9:0] e_kv, output int e_err);
        e_raw = 0; e_key = 0; e_kv = '0; e_err = 0;
        if (!good) begin
            e_err = 1;
            m_ext = 0; m_brk = 0; m_skip = 0;
        end else begin
            e_raw = 1;
            if (m_skip > 0) m_skip--;
            else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE1) m_skip = 7;
            else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
            end else begin
                e_key = 1;
                e_kv  = {~m_brk, m_ext, b};
                m_ext = 0; m_brk = 0;
            end
        end
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        clear_obs();
        send_frame(v.b, v.bad_par, v.bad_stop, 11);
        wait_cyc(2 * HALF);
        chk({tag, " raw_stb count"}, n_raw, v.e_raw);
        chk({tag, " frame_err count"}, n_err, v.e_err);
        chk({tag, " event count"}, n_key, v.e_key);
        if (v.e_raw == 1) chk({tag, " raw_code"}, last_raw, v.b);
        if (v.e_key == 1) begin
            chk({tag, " event value"}, last_key, v.e_kv);
            chk({tag, " key held"}, ps2_key, {1'b0, v.e_kv});
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input bit bp, input bit bs, input int er,
                                input int ek, input logic [9:0] kv, input int ee);
        vec_t v;
        v.b = b; v.bad_par = bp; v.bad_stop = bs;
        v.e_raw = er; v.e_key = ek; v.e_kv = kv; v.e_err = ee;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   r;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        n_raw = 0; n_key = 0; n_err = 0;
        last_raw = '0; last_key = '0;
        wait_cyc(3);
        chk("reset ps2_key", ps2_key, 0);
        chk("reset raw_code", raw_code, 0);
        chk("reset raw_stb", raw_stb, 0);
        chk("reset frame_err", frame_err, 0);
        reset = 1'b0;
        wait_cyc(5);
        chk("idle frame_err", frame_err, 0);

        // Directed vectors; decoder state carries from one row to the next
        vecs.push_back(mk(8'h1C, 0, 0, 1, 1, 10'h21C, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h75, 0, 0, 1, 1, 10'h175, 0));
        vecs.push_back(mk(8'h1C, 1, 0, 0, 0, 10'h000, 1));
        vecs.push_back(mk(8'h1C, 0, 0, 1, 1, 10'h21C, 0));
        vecs.push_back(mk(8'hE1, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h14, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h77, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'hE1, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h14, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h77, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h29, 0, 0, 1, 1, 10'h229, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'hFA, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h12, 0, 0, 1, 1, 10'h112, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h12, 0, 0, 1, 1, 10'h312, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 1, 0, 10'h000, 0));
        vecs.push_back(mk(8'h1C, 0, 1, 0, 0, 10'h000, 1));
        vecs.push_back(mk(8'h1C, 0, 0, 1, 1, 10'h21C, 0));
        for (int i = 0; i < vecs.size(); i++) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Timeout mid-frame after a break prefix
        run_frame("to_f0", mk(8'hF0, 0, 0, 1, 0, 10'h000, 0));
        clear_obs();
        send_frame(8'h1C, 0, 0, 5);
        wait_cyc(TIMEOUT + 10);
        chk("timeout frame_err count", n_err, 1);
        chk("timeout raw_stb count", n_raw, 0);
        chk("timeout event count", n_key, 0);
        run_frame("after_timeout", mk(8'h1C, 0, 0, 1, 1, 10'h21C, 0));

        // Short glitch on the clock pin must not register as an edge
        clear_obs();
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(4 * FILTER);
        chk("glitch frame_err count", n_err, 0);
        chk("glitch raw_stb count", n_raw, 0);
        run_frame("after_glitch", mk(8'h1C, 0, 0, 1, 1, 10'h21C, 0));

        // Reset part way through a frame
        clear_obs();
        send_frame(8'h29, 0, 0, 4);
        reset = 1'b1;
        #2;
        chk("midreset ps2_key", ps2_key, 0);
        chk("midreset raw_code", raw_code, 0);
        chk("midreset raw_stb", raw_stb, 0);
        chk("midreset frame_err", frame_err, 0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        run_frame("after_reset", mk(8'h29, 0, 0, 1, 1, 10'h229, 0));

        // Randomised frames against the reference decoder
        m_ext = 0; m_brk = 0; m_skip = 0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 19);
            case (r)
                0, 1, 2: v.b = 8'hE0;
                3, 4, 5: v.b = 8'hF0;
                6:       v.b = 8'hE1;
                7, 8:    v.b = (r == 7) ? 8'hFA : 8'hAA;
                default: v.b = 8'($urandom_range(0, 255));
            endcase
            r = $urandom_range(0, 19);
            v.bad_par  = (r == 0);
            v.bad_stop = (r == 1);
            model(v.b, !(v.bad_par || v.bad_stop), v.e_raw, v.e_key, v.e_kv, v.e_err);
            run_frame($sformatf("rand%0d", i), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
